// File: rtl/prf_param_pkg.sv
// Shared defaults for the parametrised physical register file, the renamer and the free list.
// Read classification type used by the read muxes.
package prf_param_pkg;

  localparam int PRF_NUM_PREGS = 96;
  localparam int PRF_DATA_W    = 64;
  localparam int PRF_IDX_W     = 7;
  localparam int PRF_NUM_RD    = 12;
  localparam int PRF_NUM_WR    = 6;
  localparam int PRF_NUM_ALLOC = 2;
  localparam int PRF_ZERO_PREG = 31;
  localparam int PRF_CNT_W     = 7;

  typedef enum logic [1:0] {
    RD_NORMAL,
    RD_ZERO,
    RD_RANGE
  } rd_kind_e;

endpackage

// File: rtl/prf_wr_select.sv
// Per-entry writeback priority mux: the highest-numbered enabled port addressing ENTRY wins.
// multi flags two or more enabled ports addressing ENTRY in the same cycle.
module prf_wr_select #(
  parameter int NUM_WR = 6,
  parameter int IDX_W  = 7,
  parameter int DATA_W = 64,
  parameter int ENTRY  = 0
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*IDX_W-1:0]  wr_idx,
  input  logic [NUM_WR*DATA_W-1:0] wr_value,
  output logic                     hit,
  output logic [DATA_W-1:0]        data,
  output logic                     multi
);

  always_comb begin
    hit   = 1'b0;
    data  = '0;
    multi = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] == IDX_W'(ENTRY))) begin
        multi = multi | hit;
        hit   = 1'b1;
        data  = wr_value[w*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/prf_param.sv
// Parametrised physical register file with ready scoreboard, zero register and write-conflict flag.
// Optional macro PRF_BYPASS_EN forwards same-cycle writeback data to the read ports.
module prf_param
  import prf_param_pkg::*;
#(
  parameter int NUM_PREGS = PRF_NUM_PREGS,
  parameter int DATA_W    = PRF_DATA_W,
  parameter int IDX_W     = PRF_IDX_W,
  parameter int NUM_RD    = PRF_NUM_RD,
  parameter int NUM_WR    = PRF_NUM_WR,
  parameter int NUM_ALLOC = PRF_NUM_ALLOC,
  parameter int ZERO_PREG = PRF_ZERO_PREG,
  parameter int CNT_W     = PRF_CNT_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_RD*IDX_W-1:0]     rd_idx,
  output logic [NUM_RD*DATA_W-1:0]    rd_value,
  output logic [NUM_RD-1:0]           rd_ready,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*IDX_W-1:0]     wr_idx,
  input  logic [NUM_WR*DATA_W-1:0]    wr_value,
  input  logic [NUM_ALLOC-1:0]        alloc_en,
  input  logic [NUM_ALLOC*IDX_W-1:0]  alloc_idx,
  output logic                        wr_conflict,
  output logic [CNT_W-1:0]            ready_count
);

  localparam logic [IDX_W:0] NUM_PREGS_X = (IDX_W+1)'(NUM_PREGS);

  logic [NUM_PREGS-1:0] ent_hit;
  logic [NUM_PREGS-1:0] ent_multi;
  logic [NUM_PREGS-1:0] ent_alloc;
  logic [NUM_PREGS-1:0] ready_q;
  logic [NUM_PREGS-1:0] ready_d;
  logic [DATA_W-1:0]    ent_data [NUM_PREGS];
  logic [DATA_W-1:0]    regs_q   [NUM_PREGS];
  logic [CNT_W-1:0]     count_d;

  for (genvar e = 0; e < NUM_PREGS; e++) begin : g_ent
    prf_wr_select #(
      .NUM_WR (NUM_WR),
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W),
      .ENTRY  (e)
    ) u_sel (
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_value (wr_value),
      .hit      (ent_hit[e]),
      .data     (ent_data[e]),
      .multi    (ent_multi[e])
    );
  end

  always_comb begin
    ent_alloc = '0;
    for (int e = 0; e < NUM_PREGS; e++) begin
      for (int a = 0; a < NUM_ALLOC; a++) begin
        if (alloc_en[a] && (alloc_idx[a*IDX_W +: IDX_W] == IDX_W'(e)) && (e != ZERO_PREG)) begin
          ent_alloc[e] = 1'b1;
        end
      end
    end
  end

  // Alloc beats writeback on the ready bit; the count is taken from the next-state vector
  always_comb begin
    ready_d = ready_q;
    count_d = '0;
    for (int e = 0; e < NUM_PREGS; e++) begin
      if (e == ZERO_PREG) begin
        ready_d[e] = 1'b1;
      end else if (ent_alloc[e]) begin
        ready_d[e] = 1'b0;
      end else if (ent_hit[e]) begin
        ready_d[e] = 1'b1;
      end
      count_d = count_d + CNT_W'(ready_d[e]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < NUM_PREGS; e++) begin
        regs_q[e] <= '0;
      end
      ready_q     <= '1;
      wr_conflict <= 1'b0;
      ready_count <= CNT_W'(NUM_PREGS);
    end else begin
      for (int e = 0; e < NUM_PREGS; e++) begin
        if (ent_hit[e] && (e != ZERO_PREG)) begin
          regs_q[e] <= ent_data[e];
        end
      end
      ready_q     <= ready_d;
      wr_conflict <= |ent_multi;
      ready_count <= count_d;
    end
  end

  always_comb begin
    logic [IDX_W-1:0] idx;
    rd_kind_e         kind;
    rd_value = '0;
    rd_ready = '0;
    idx      = '0;
    kind     = RD_NORMAL;
    for (int r = 0; r < NUM_RD; r++) begin
      idx = rd_idx[r*IDX_W +: IDX_W];
      if (idx == IDX_W'(ZERO_PREG)) begin
        kind = RD_ZERO;
      end else if ({1'b0, idx} >= NUM_PREGS_X) begin
        kind = RD_RANGE;
      end else begin
        kind = RD_NORMAL;
      end
      case (kind)
        RD_ZERO:  rd_ready[r] = 1'b1;
        RD_RANGE: rd_ready[r] = 1'b0;
        default: begin
          rd_value[r*DATA_W +: DATA_W] = regs_q[idx];
          rd_ready[r]                  = ready_q[idx];
`ifdef PRF_BYPASS_EN
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] == idx)) begin
              rd_value[r*DATA_W +: DATA_W] = wr_value[w*DATA_W +: DATA_W];
              rd_ready[r]                  = 1'b1;
            end
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prf_param.sv
// Scoreboard bench for prf_param: stimulus queues expected responses tagged with the cycle they
// must appear in; a negedge monitor pops and compares them against the live outputs.
module tb_prf_param;

  localparam int NRD = 12;
  localparam int NWR = 6;
  localparam int NAL = 2;
  localparam int IW  = 7;
  localparam int DW  = 64;

  localparam int K_VAL  = 0;
  localparam int K_RDY  = 1;
  localparam int K_CNT  = 2;
  localparam int K_CONF = 3;

  logic               clock = 1'b0;
  logic               reset;
  logic [NRD*IW-1:0]  rd_idx;
  logic [NRD*DW-1:0]  rd_value;
  logic [NRD-1:0]     rd_ready;
  logic [NWR-1:0]     wr_en;
  logic [NWR*IW-1:0]  wr_idx;
  logic [NWR*DW-1:0]  wr_value;
  logic [NAL-1:0]     alloc_en;
  logic [NAL*IW-1:0]  alloc_idx;
  logic               wr_conflict;
  logic [6:0]         ready_count;

  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  prf_param dut (
    .clock       (clock),
    .reset       (reset),
    .rd_idx      (rd_idx),
    .rd_value    (rd_value),
    .rd_ready    (rd_ready),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_value    (wr_value),
    .alloc_en    (alloc_en),
    .alloc_idx   (alloc_idx),
    .wr_conflict (wr_conflict),
    .ready_count (ready_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input exp_t it);
    logic [63:0] act;
    case (it.kind)
      K_VAL:   act = rd_value[it.port*DW +: DW];
      K_RDY:   act = {63'd0, rd_ready[it.port]};
      K_CNT:   act = {57'd0, ready_count};
      default: act = {63'd0, wr_conflict};
    endcase
    total++;
    if (act !== it.val) begin
      bad++;
      $display("[TB] FAIL %s (cycle %0d port %0d): got %0h expected %0h",
               it.name, it.cyc, it.port, act, it.val);
    end
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_item = sb.pop_front();
      checkOutput(mon_item);
    end
  end

  task automatic expect_out(input int dc, input int kind, input int port,
                            input logic [63:0] val, input string name);
    exp_t it;
    int   pos;
    it.cyc  = cyc + dc;
    it.kind = kind;
    it.port = port;
    it.val  = val;
    it.name = name;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > it.cyc) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, it);
  endtask

  task automatic set_rd(input int port, input int idx);
    rd_idx[port*IW +: IW] = IW'(idx);
  endtask

  task automatic set_wr(input int port, input int idx, input logic [63:0] val);
    wr_en[port]              = 1'b1;
    wr_idx[port*IW +: IW]    = IW'(idx);
    wr_value[port*DW +: DW]  = val;
  endtask

  task automatic set_alloc(input int port, input int idx);
    alloc_en[port]             = 1'b1;
    alloc_idx[port*IW +: IW]   = IW'(idx);
  endtask

  // Advance one cycle; enables are single-cycle pulses
  task automatic applyStimulus();
    @(posedge clock);
    #1;
    wr_en    = '0;
    alloc_en = '0;
  endtask

  initial begin
    reset     = 1'b1;
    rd_idx    = '0;
    wr_en     = '0;
    wr_idx    = '0;
    wr_value  = '0;
    alloc_en  = '0;
    alloc_idx = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    expect_out(0, K_CNT, 0, 64'd96, "reset_count");
    expect_out(0, K_CONF, 0, 64'd0, "reset_conflict");
    for (int base = 0; base < 128; base += NRD) begin
      for (int k = 0; k < NRD; k++) begin
        int idx;
        idx = (base + k) % 128;
        set_rd(k, idx);
        expect_out(0, K_VAL, k, 64'd0, "reset_value");
        expect_out(0, K_RDY, k, (idx < 96) ? 64'd1 : 64'd0, "reset_ready");
      end
      applyStimulus();
    end

    // Alloc 40, idle, then writeback 40
    set_rd(0, 40);
    set_alloc(0, 40);
    expect_out(0, K_RDY, 0, 64'd1, "alloc_before_ready");
    expect_out(1, K_RDY, 0, 64'd0, "alloc_ready");
    expect_out(1, K_CNT, 0, 64'd95, "alloc_count");
    applyStimulus();
    applyStimulus();
    set_wr(0, 40, 64'hDEAD_BEEF);
`ifdef PRF_BYPASS_EN
    expect_out(0, K_VAL, 0, 64'hDEAD_BEEF, "wb_sameclk_value");
    expect_out(0, K_RDY, 0, 64'd1, "wb_sameclk_ready");
`else
    expect_out(0, K_VAL, 0, 64'd0, "wb_sameclk_value");
    expect_out(0, K_RDY, 0, 64'd0, "wb_sameclk_ready");
`endif
    expect_out(1, K_VAL, 0, 64'hDEAD_BEEF, "wb_value");
    expect_out(1, K_RDY, 0, 64'd1, "wb_ready");
    expect_out(1, K_CNT, 0, 64'd96, "wb_count");
    applyStimulus();

    // Two writers on idx 10
    set_rd(1, 10);
    set_wr(1, 10, 64'd11);
    set_wr(4, 10, 64'd44);
    expect_out(0, K_CONF, 0, 64'd0, "conf_before");
    expect_out(1, K_VAL, 1, 64'd44, "conf_winner");
    expect_out(1, K_CONF, 0, 64'd1, "conf_set");
    expect_out(2, K_CONF, 0, 64'd0, "conf_clear");
    applyStimulus();
    applyStimulus();

    // Single write to the zero register
    set_rd(2, 31);
    set_wr(2, 31, 64'h5);
    expect_out(0, K_VAL, 2, 64'd0, "zero_sameclk_value");
    expect_out(1, K_VAL, 2, 64'd0, "zero_value");
    expect_out(1, K_RDY, 2, 64'd1, "zero_ready");
    expect_out(1, K_CONF, 0, 64'd0, "zero_no_conf");
    applyStimulus();

    // Zero register still counts toward conflicts
    set_wr(0, 31, 64'h1);
    set_wr(5, 31, 64'h2);
    set_alloc(1, 31);
    expect_out(1, K_CONF, 0, 64'd1, "zero_conf");
    expect_out(1, K_VAL, 2, 64'd0, "zero_conf_value");
    expect_out(1, K_CNT, 0, 64'd96, "zero_alloc_count");
    applyStimulus();

    // Alloc and write to idx 50 together
    set_rd(3, 50);
    set_alloc(1, 50);
    set_wr(3, 50, 64'd7);
    expect_out(1, K_RDY, 3, 64'd0, "allocwr_ready");
    expect_out(1, K_VAL, 3, 64'd7, "allocwr_value");
    expect_out(1, K_CNT, 0, 64'd95, "allocwr_count");
    applyStimulus();

    // Out-of-range write and alloc are ignored
    set_rd(4, 100);
    set_wr(0, 100, 64'h1234);
    set_alloc(0, 100);
    expect_out(1, K_VAL, 4, 64'd0, "oor_value");
    expect_out(1, K_RDY, 4, 64'd0, "oor_ready");
    expect_out(1, K_CNT, 0, 64'd95, "oor_count");
    applyStimulus();

    // Write and read idx 20 in the same cycle
    set_rd(5, 20);
    set_wr(2, 20, 64'h99);
`ifdef PRF_BYPASS_EN
    expect_out(0, K_VAL, 5, 64'h99, "byp_sameclk_value");
`else
    expect_out(0, K_VAL, 5, 64'd0, "byp_sameclk_value");
`endif
    expect_out(0, K_RDY, 5, 64'd1, "byp_sameclk_ready");
    expect_out(1, K_VAL, 5, 64'h99, "byp_next_value");
    applyStimulus();

    // Reset mid-operation with conflicting writes and an alloc pending
    reset = 1'b1;
    set_wr(1, 10, 64'hAA);
    set_wr(4, 10, 64'hBB);
    set_alloc(0, 60);
    applyStimulus();
    reset = 1'b0;
    set_rd(0, 40);
    set_rd(1, 10);
    set_rd(3, 50);
    set_rd(5, 20);
    set_rd(6, 60);
    expect_out(0, K_VAL, 0, 64'd0, "rst2_value40");
    expect_out(0, K_VAL, 1, 64'd0, "rst2_value10");
    expect_out(0, K_RDY, 3, 64'd1, "rst2_ready50");
    expect_out(0, K_VAL, 5, 64'd0, "rst2_value20");
    expect_out(0, K_RDY, 6, 64'd1, "rst2_ready60");
    expect_out(0, K_CNT, 0, 64'd96, "rst2_count");
    expect_out(0, K_CONF, 0, 64'd0, "rst2_conflict");
    applyStimulus();
    applyStimulus();
    applyStimulus();

    while (sb.size() > 0) begin
      mon_item = sb.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL %s never checked (cycle %0d): got none expected %0h",
               mon_item.name, mon_item.cyc, mon_item.val);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
